seq_step_detector: RTL

//  Overlapping serial-pattern detector fed by the debounced one-shot step pulse.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_step_detector_step_edge.sv | 18 +
 rtl/seq_step_detector.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults, FSM state type and fill-counter sizing for the serial step detector.
package seq_det_pkg;

  localparam int unsigned            SEQ_LEN_DEF     = 4;
  localparam logic [SEQ_LEN_DEF-1:0] SEQ_PATTERN_DEF = 4'b1011;
  localparam int unsigned            SEQ_CNT_W_DEF   = 8;
  localparam int unsigned            SEQ_FILL_W_DEF  = $clog2(SEQ_LEN_DEF + 1);

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } seq_state_e;

  // Fill counter has to reach LEN itself, hence LEN+1 codes.
  function automatic int unsigned fill_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_step_detector_step_edge.sv
// One-shot rising-edge extractor for the debounced step pulse; a held step yields a single enable.
module step_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_i,
  output logic edge_o
);

  logic step_dly_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) step_dly_q <= 1'b0;
    else         step_dly_q <= step_i;
  end

  assign edge_o = step_i & ~step_dly_q;

endmodule

// File: rtl/seq_step_detector.sv
// Overlapping serial-pattern detector clocked by clk_in, advanced by step edges.
// Optional runtime pattern load via SEQ_PATTERN_LOAD_EN.
module seq_step_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned     LEN     = SEQ_LEN_DEF,
  parameter logic [LEN-1:0]  PATTERN = SEQ_PATTERN_DEF,
  parameter int unsigned     CNT_W   = SEQ_CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             step,
  input  logic             bit_in,
  input  logic             clear,
`ifdef SEQ_PATTERN_LOAD_EN
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
`endif
  output logic             detect,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN-1:0]   hist
);

  localparam int unsigned        FILL_W    = fill_width(LEN);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(LEN);

  logic              step_edge_w;
  logic [LEN-1:0]    pattern_w;

  logic [LEN-1:0]    hist_q,   hist_d;
  logic [FILL_W-1:0] fill_q,   fill_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              detect_q, detect_d;
  seq_state_e        state_q,  state_d;

  step_edge u_step_edge (
    .clk_i  (clk_in),
    .rst_ni (reset_n),
    .step_i (step),
    .edge_o (step_edge_w)
  );

`ifdef SEQ_PATTERN_LOAD_EN
  logic [LEN-1:0] pattern_q, pattern_d;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) pattern_q <= PATTERN;
    else          pattern_q <= pattern_d;
  end

  assign pattern_w = pattern_q;
`else
  assign pattern_w = PATTERN;
`endif

  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    detect_d = 1'b0;
    state_d  = state_q;
`ifdef SEQ_PATTERN_LOAD_EN
    pattern_d = pattern_q;
`endif
    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
      state_d = FILLING;
    end
`ifdef SEQ_PATTERN_LOAD_EN
    else if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = FILLING;
    end
`endif
    else if (step_edge_w) begin
      hist_d = {hist_q[LEN-2:0], bit_in};
      if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
      if (fill_d == FILL_FULL) state_d = ARMED;
      // Match is judged on the post-shift history so overlapping hits are seen.
      if ((fill_d == FILL_FULL) && (hist_d == pattern_w)) begin
        detect_d = 1'b1;
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      hist_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      detect_q <= 1'b0;
      state_q  <= FILLING;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      detect_q <= detect_d;
      state_q  <= state_d;
    end
  end

  assign detect    = detect_q;
  assign armed     = (state_q == ARMED);
  assign match_cnt = cnt_q;
  assign hist      = hist_q;

endmodule
